alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0, meaning 0 = round-robin arbitration, 1 = requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid / req1_valid  input  1  requester 0 (execute) / 1 (address generation) has an operation.
REQ-005 req0_ready / req1_ready  output  1  operation accepted this cycle when valid and ready both high.
REQ-006 req0_lhs, req0_rhs / req1_lhs, req1_rhs  input  32  operands per requester.
REQ-007 req0_uop / req1_uop  input  5  micro-operation (Utilities encodings: NOP, ADD, SUB, AND, EOR, CMP, LSL, LSR, MOV, STR, LDR).
REQ-008 alu_lhs, alu_rhs  output  32; alu_uop  output  5  operands and uop driven to the shared ALU.
REQ-009 alu_out  input  32; alu_flags  input  4  combinational ALU result and NZCV flags.
REQ-010 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-011 rsp_id  output  1  requester that issued the held response.
REQ-012 rsp_data  output  32; rsp_flags  output  4  registered ALU result and flags.
REQ-013 nzcv  output  4  architectural flags register.
REQ-014 flush  input  1  synchronous discard of held response and blocking of new grants.

Function
REQ-015 One-entry response buffer; states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 Buffer "free" this cycle = EMPTY, or FULL with rsp_ready=1 (drain and refill same cycle).
REQ-017 Grant only when buffer free and flush=0; at most one requester granted per cycle; reqN_ready high only for the granted requester.
REQ-018 reqN_ready combinationally depends on valids, buffer state, rsp_ready, flush; never high without corresponding grant.
REQ-019 Round-robin (FIXED_PRIO=0): single valid wins; both valid -> requester not granted last wins; last_grant updates only on an accepted transfer.
REQ-020 FIXED_PRIO=1: requester 0 wins whenever req0_valid=1.
REQ-021 alu_lhs/alu_rhs/alu_uop = granted requester's inputs; with no grant, all zero (alu_uop=NOP).
REQ-022 On accepted transfer, at the clock edge: rsp_data<=alu_out, rsp_flags<=alu_flags, rsp_id<=grantee, state FULL; latency exactly 1 cycle (accept cycle N -> rsp_valid cycle N+1).
REQ-023 FULL with rsp_ready=1 and no new grant -> EMPTY; FULL with rsp_ready=0 -> hold all rsp_* stable.
REQ-024 nzcv updates at the same edge as capture, with alu_flags, only for uop in {ADD, SUB, AND, EOR, CMP, LSL, LSR, MOV}; NOP, STR, LDR, unknown uops leave nzcv unchanged.
REQ-025 nzcv update order equals grant order; a later flag-setting op overwrites an earlier one regardless of response drain.
REQ-026 flush=1: state -> EMPTY at next edge, no grant that cycle, held response dropped (no handshake); nzcv unaffected by flush.
REQ-027 flush and rsp_ready both high with FULL: response counts as not delivered; state EMPTY.
REQ-028 Requester that drops valid without ready leaves arbitration state unchanged.

Reset
REQ-029 rst_n low asynchronously forces: state EMPTY, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0, nzcv=0, last_grant=1 (requester 0 wins first tie).
REQ-030 Reset mid-operation discards held response; no partial nzcv update; outputs valid within same cycle as rst_n falling.
REQ-031 First grant possible on first rising edge after rst_n deasserts.

Verification
REQ-032 After reset, both valid (req0 ADD 5+3, req1 SUB 2-7), rsp_ready=1 -> cycle1 rsp id0 data 8 flags 0000; cycle2 id1 data 0xFFFFFFFB flags 1000; nzcv=1000.
REQ-033 FULL, rsp_ready=0 for 3 cycles, req0 valid -> req0_ready=0 throughout, rsp_* stable; rsp_ready=1 -> drain and req0 accepted same cycle.
REQ-034 req1 LDR lhs 0x100 rhs 4 after CMP 4-4 -> rsp_data 0x104, rsp_flags 0000, nzcv stays 0100.
REQ-035 FIXED_PRIO=1, both valid continuously for 4 cycles -> req0 granted all 4, req1_ready never high.
REQ-036 FULL with flush=1 and req0 valid -> next cycle rsp_valid=0, req0 not accepted that cycle; accepted following cycle.
REQ-037 rst_n pulsed low while FULL with ADD 0xFFFFFFFF+1 held -> rsp_valid=0, nzcv=0000 immediately, no response ever delivered.

Source files
------------

// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module   : alu_arbiter
//  Brief    : Two-requester arbiter for a shared combinational ALU, with a
//             one-entry response buffer and an architectural NZCV register.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_lhs,
    input  logic [31:0] req0_rhs,
    input  logic [4:0]  req0_uop,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_lhs,
    input  logic [31:0] req1_rhs,
    input  logic [4:0]  req1_uop,

    output logic [31:0] alu_lhs,
    output logic [31:0] alu_rhs,
    output logic [4:0]  alu_uop,
    input  logic [31:0] alu_out,
    input  logic [3:0]  alu_flags,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_flags,

    output logic [3:0]  nzcv,
    input  logic        flush
);

    localparam logic [4:0] c_UOP_NOP = 5'd0;
    localparam logic [4:0] c_UOP_ADD = 5'd1;
    localparam logic [4:0] c_UOP_SUB = 5'd2;
    localparam logic [4:0] c_UOP_AND = 5'd3;
    localparam logic [4:0] c_UOP_EOR = 5'd4;
    localparam logic [4:0] c_UOP_CMP = 5'd5;
    localparam logic [4:0] c_UOP_LSL = 5'd6;
    localparam logic [4:0] c_UOP_LSR = 5'd7;
    localparam logic [4:0] c_UOP_MOV = 5'd8;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic [3:0]  nzcv_q, nzcv_d;

    logic        w_buf_free;
    logic        w_grant_en;
    logic        w_pick1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_accept;

    function automatic logic sets_flags(input logic [4:0] uop);
        case (uop)
            c_UOP_ADD, c_UOP_SUB, c_UOP_AND, c_UOP_EOR,
            c_UOP_CMP, c_UOP_LSL, c_UOP_LSR, c_UOP_MOV: sets_flags = 1'b1;
            default:                                    sets_flags = 1'b0;
        endcase
    endfunction

    // A full buffer that is draining this cycle can be refilled at the same edge.
    assign w_buf_free = (state_q == ST_EMPTY) || rsp_ready;
    assign w_grant_en = w_buf_free && !flush;

    generate
        if (FIXED_PRIO != 0) begin : g_fixed_prio
            assign w_pick1 = !req0_valid;
        end else begin : g_round_robin
            assign w_pick1 = req1_valid && (!req0_valid || !last_grant_q);
        end
    endgenerate

    assign w_gnt0   = w_grant_en && req0_valid && !w_pick1;
    assign w_gnt1   = w_grant_en && req1_valid &&  w_pick1;
    assign w_accept = w_gnt0 || w_gnt1;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        alu_lhs = 32'd0;
        alu_rhs = 32'd0;
        alu_uop = c_UOP_NOP;
        if (w_gnt0) begin
            alu_lhs = req0_lhs;
            alu_rhs = req0_rhs;
            alu_uop = req0_uop;
        end else if (w_gnt1) begin
            alu_lhs = req1_lhs;
            alu_rhs = req1_rhs;
            alu_uop = req1_uop;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_flags_d  = rsp_flags_q;
        nzcv_d       = nzcv_q;
        if (flush) begin
            // Held response is dropped without a handshake.
            state_d = ST_EMPTY;
        end else if (w_accept) begin
            state_d      = ST_FULL;
            last_grant_d = w_gnt1;
            rsp_id_d     = w_gnt1;
            rsp_data_d   = alu_out;
            rsp_flags_d  = alu_flags;
            if (sets_flags(alu_uop)) begin
                nzcv_d = alu_flags;
            end
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_flags_q  <= 4'd0;
            nzcv_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flags_q  <= rsp_flags_d;
            nzcv_q       <= nzcv_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign nzcv      = nzcv_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
//  Module   : tb_alu_arbiter
//  Brief    : Scoreboard bench for alu_arbiter (round-robin and fixed-priority).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam logic [4:0] NOP = 5'd0, ADD = 5'd1, SUB = 5'd2, AND_ = 5'd3,
                           EOR = 5'd4, CMP = 5'd5, LSL = 5'd6, LSR = 5'd7,
                           MOV = 5'd8, STR = 5'd9, LDR = 5'd10;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic [3:0]  flags;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Round-robin instance signals
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_lhs, req0_rhs, req1_lhs, req1_rhs;
    logic [4:0]  req0_uop, req1_uop;
    logic [31:0] alu_lhs, alu_rhs, alu_out;
    logic [4:0]  alu_uop;
    logic [3:0]  alu_flags;
    logic        rsp_valid, rsp_ready, rsp_id, flush;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags, nzcv;

    // Fixed-priority instance signals
    logic        fp_req0_valid, fp_req0_ready, fp_req1_valid, fp_req1_ready;
    logic [31:0] fp_req0_lhs, fp_req0_rhs, fp_req1_lhs, fp_req1_rhs;
    logic [4:0]  fp_req0_uop, fp_req1_uop;
    logic [31:0] fp_alu_lhs, fp_alu_rhs, fp_alu_out;
    logic [4:0]  fp_alu_uop;
    logic [3:0]  fp_alu_flags;
    logic        fp_rsp_valid, fp_rsp_ready, fp_rsp_id, fp_flush;
    logic [31:0] fp_rsp_data;
    logic [3:0]  fp_rsp_flags, fp_nzcv;

    // Shared ALU model: {N,Z,C,V, result}
    function automatic logic [35:0] alu_model(input logic [4:0] uop,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        r = 32'd0; c = 1'b0; v = 1'b0; s = 33'd0;
        case (uop)
            ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            SUB, CMP: begin
                r = a - b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            AND_: r = a & b;
            EOR:  r = a ^ b;
            LSL:  r = a << b[4:0];
            LSR:  r = a >> b[4:0];
            MOV:  r = b;
            STR, LDR: r = a + b;
            default: r = 32'd0;
        endcase
        if (uop == STR || uop == LDR || uop == NOP)
            alu_model = {4'b0000, r};
        else
            alu_model = {r[31], (r == 32'd0), c, v, r};
    endfunction

    logic [35:0] w_alu, w_fp_alu;
    assign w_alu        = alu_model(alu_uop, alu_lhs, alu_rhs);
    assign alu_out      = w_alu[31:0];
    assign alu_flags    = w_alu[35:32];
    assign w_fp_alu     = alu_model(fp_alu_uop, fp_alu_lhs, fp_alu_rhs);
    assign fp_alu_out   = w_fp_alu[31:0];
    assign fp_alu_flags = w_fp_alu[35:32];

    alu_arbiter #(.FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_lhs(req0_lhs), .req0_rhs(req0_rhs), .req0_uop(req0_uop),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_lhs(req1_lhs), .req1_rhs(req1_rhs), .req1_uop(req1_uop),
        .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_uop(alu_uop),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .nzcv(nzcv), .flush(flush)
    );

    alu_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready),
        .req0_lhs(fp_req0_lhs), .req0_rhs(fp_req0_rhs), .req0_uop(fp_req0_uop),
        .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready),
        .req1_lhs(fp_req1_lhs), .req1_rhs(fp_req1_rhs), .req1_uop(fp_req1_uop),
        .alu_lhs(fp_alu_lhs), .alu_rhs(fp_alu_rhs), .alu_uop(fp_alu_uop),
        .alu_out(fp_alu_out), .alu_flags(fp_alu_flags),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_data(fp_rsp_data), .rsp_flags(fp_rsp_flags),
        .nzcv(fp_nzcv), .flush(fp_flush)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    rsp_t sb[$];
    rsp_t exp0, exp1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accepted requests push their hand-computed response.
    always @(negedge clk) begin
        if (req0_valid && req0_ready) sb.push_back(exp0);
        if (req1_valid && req1_ready) sb.push_back(exp1);
    end

    // Response monitor: flush drops the held entry, a handshake pops and compares.
    always @(negedge clk) begin
        rsp_t e;
        if (flush && rsp_valid) begin
            if (sb.size() > 0) e = sb.pop_front();
        end else if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id",    {63'd0, rsp_id}, {63'd0, e.id});
                chk("rsp_data",  {32'd0, rsp_data}, {32'd0, e.data});
                chk("rsp_flags", {60'd0, rsp_flags}, {60'd0, e.flags});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic [4:0] u, input logic [31:0] l, input logic [31:0] r,
                          input logic [31:0] d, input logic [3:0] f);
        req0_valid = 1'b1; req0_uop = u; req0_lhs = l; req0_rhs = r;
        exp0 = '{id: 1'b0, data: d, flags: f};
    endtask

    task automatic drive1(input logic [4:0] u, input logic [31:0] l, input logic [31:0] r,
                          input logic [31:0] d, input logic [3:0] f);
        req1_valid = 1'b1; req1_uop = u; req1_lhs = l; req1_rhs = r;
        exp1 = '{id: 1'b1, data: d, flags: f};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_lhs = '0; req0_rhs = '0; req0_uop = NOP;
        req1_valid = 1'b0; req1_lhs = '0; req1_rhs = '0; req1_uop = NOP;
        fp_req0_valid = 1'b0; fp_req0_lhs = '0; fp_req0_rhs = '0; fp_req0_uop = NOP;
        fp_req1_valid = 1'b0; fp_req1_lhs = '0; fp_req1_rhs = '0; fp_req1_uop = NOP;
        fp_rsp_ready = 1'b0; fp_flush = 1'b0;
        exp0 = '0; exp1 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_rsp_id",    {63'd0, rsp_id}, 64'd0);
        chk("reset_rsp_data",  {32'd0, rsp_data}, 64'd0);
        chk("reset_rsp_flags", {60'd0, rsp_flags}, 64'd0);
        chk("reset_nzcv",      {60'd0, nzcv}, 64'd0);
        chk("idle_alu_uop",    {59'd0, alu_uop}, 64'd0);

        // Tie right after reset: requester 0 first, then 1
        tick();
        rst_n = 1'b1; rsp_ready = 1'b1;
        drive0(ADD, 32'd5, 32'd3, 32'd8, 4'b0000);
        drive1(SUB, 32'd2, 32'd7, 32'hFFFF_FFFB, 4'b1000);
        @(negedge clk);
        chk("tie0_req0_ready", {63'd0, req0_ready}, 64'd1);
        chk("tie0_req1_ready", {63'd0, req1_ready}, 64'd0);
        chk("tie0_alu_uop",    {59'd0, alu_uop}, {59'd0, ADD});
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("latency_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("latency_rsp_id",    {63'd0, rsp_id}, 64'd0);
        chk("tie0_req1_next",    {63'd0, req1_ready}, 64'd1);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("second_rsp_id", {63'd0, rsp_id}, 64'd1);
        tick();
        @(negedge clk);
        chk("drained_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("sub_nzcv",          {60'd0, nzcv}, {60'd0, 4'b1000});

        // Backpressure: held response stays stable, no new grant
        tick();
        rsp_ready = 1'b0;
        drive0(ADD, 32'd10, 32'd20, 32'd30, 4'b0000);
        @(negedge clk);
        chk("bp_first_ready", {63'd0, req0_ready}, 64'd1);
        tick();
        drive0(AND_, 32'hF0, 32'h3C, 32'h30, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_req0_ready", {63'd0, req0_ready}, 64'd0);
            chk("bp_rsp_valid",  {63'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_data",   {32'd0, rsp_data}, 64'd30);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_refill", {63'd0, req0_ready}, 64'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("bp_refill_data", {32'd0, rsp_data}, 64'h30);

        // LDR after CMP leaves nzcv alone
        tick();
        drive0(CMP, 32'd4, 32'd4, 32'd0, 4'b0100);
        @(negedge clk);
        tick();
        req0_valid = 1'b0;
        drive1(LDR, 32'h100, 32'd4, 32'h104, 4'b0000);
        @(negedge clk);
        chk("ldr_req1_ready", {63'd0, req1_ready}, 64'd1);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("ldr_nzcv", {60'd0, nzcv}, {60'd0, 4'b0100});
        tick();
        @(negedge clk);
        chk("ldr_nzcv_hold", {60'd0, nzcv}, {60'd0, 4'b0100});

        // Tie after a requester-0 grant: requester 1 wins; later EOR overwrites MOV flags
        tick();
        drive0(LSR, 32'h80, 32'd3, 32'h10, 4'b0000);
        @(negedge clk);
        tick();
        drive0(EOR, 32'hFF, 32'h0F, 32'hF0, 4'b0000);
        drive1(MOV, 32'd0, 32'h8000_0000, 32'h8000_0000, 4'b1000);
        @(negedge clk);
        chk("tie1_req1_ready", {63'd0, req1_ready}, 64'd1);
        chk("tie1_req0_ready", {63'd0, req0_ready}, 64'd0);
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        chk("tie1_req0_next", {63'd0, req0_ready}, 64'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("order_nzcv", {60'd0, nzcv}, 64'd0);

        // Flush drops held response and blocks the grant for one cycle
        tick();
        rsp_ready = 1'b0;
        drive0(ADD, 32'd1, 32'd1, 32'd2, 4'b0000);
        @(negedge clk);
        tick();
        drive0(ADD, 32'd2, 32'd2, 32'd4, 4'b0000);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_req0_ready", {63'd0, req0_ready}, 64'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("post_flush_ready", {63'd0, req0_ready}, 64'd1);
        tick();
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_flush_data", {32'd0, rsp_data}, 64'd4);

        // Asynchronous reset while a flag-setting response is held
        tick();
        rsp_ready = 1'b0;
        drive0(ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110);
        @(negedge clk);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("held_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("held_nzcv",      {60'd0, nzcv}, {60'd0, 4'b0110});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("async_rst_nzcv",  {60'd0, nzcv}, 64'd0);
        chk("async_rst_data",  {32'd0, rsp_data}, 64'd0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", {63'd0, rsp_valid}, 64'd0);
        end

        // Fixed priority: requester 0 wins every cycle
        tick();
        fp_rsp_ready = 1'b1;
        fp_req0_valid = 1'b1; fp_req0_uop = ADD; fp_req0_lhs = 32'd1; fp_req0_rhs = 32'd2;
        fp_req1_valid = 1'b1; fp_req1_uop = SUB; fp_req1_lhs = 32'd9; fp_req1_rhs = 32'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fp_req0_ready", {63'd0, fp_req0_ready}, 64'd1);
            chk("fp_req1_ready", {63'd0, fp_req1_ready}, 64'd0);
            tick();
        end
        fp_req0_valid = 1'b0;
        fp_req1_valid = 1'b0;

        tick();
        @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
